// File: rtl/mem_lsu_pkg.sv
// -----------------------------------------------------------------------------
// mem_lsu_pkg
// Definitions shared by the memory-access stage (mem_lsu) and its lane helper
// (mem_lsu_align):
//   - load/store op codes, using the same encoding as the execute stage
//   - LSU state encoding (2 bits)
//   - byte-strobe constants
//   - small op-classification helpers
// -----------------------------------------------------------------------------
package mem_lsu_pkg;

    // Execute-stage op codes that the LSU needs to recognise.
    localparam logic [7:0] EXE_ADD_OP   = 8'h20;
    localparam logic [7:0] EXE_LD_B_OP  = 8'hE0;
    localparam logic [7:0] EXE_LD_H_OP  = 8'hE1;
    localparam logic [7:0] EXE_LD_W_OP  = 8'hE3;
    localparam logic [7:0] EXE_LD_BU_OP = 8'hE4;
    localparam logic [7:0] EXE_LD_HU_OP = 8'hE5;
    localparam logic [7:0] EXE_ST_B_OP  = 8'hE8;
    localparam logic [7:0] EXE_ST_H_OP  = 8'hE9;
    localparam logic [7:0] EXE_ST_W_OP  = 8'hEB;

    // Byte-write strobes.
    localparam logic [3:0] WE_NONE = 4'b0000;
    localparam logic [3:0] WE_BYTE = 4'b0001;
    localparam logic [3:0] WE_HALF = 4'b0011;
    localparam logic [3:0] WE_WORD = 4'b1111;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_WAIT  = 2'd2,
        S_DRAIN = 2'd3
    } lsu_state_e;

    function automatic logic is_load(input logic [7:0] op);
        return (op == EXE_LD_B_OP) || (op == EXE_LD_H_OP) || (op == EXE_LD_W_OP) ||
               (op == EXE_LD_BU_OP) || (op == EXE_LD_HU_OP);
    endfunction

    function automatic logic is_store(input logic [7:0] op);
        return (op == EXE_ST_B_OP) || (op == EXE_ST_H_OP) || (op == EXE_ST_W_OP);
    endfunction

    // Halfword access needs addr[0] clear, word access needs addr[1:0] clear.
    function automatic logic is_misaligned(input logic [7:0] op, input logic [1:0] lo);
        logic half, word;
        half = (op == EXE_LD_H_OP) || (op == EXE_LD_HU_OP) || (op == EXE_ST_H_OP);
        word = (op == EXE_LD_W_OP) || (op == EXE_ST_W_OP);
        return (half && lo[0]) || (word && (lo != 2'b00));
    endfunction

endpackage

// File: rtl/mem_lsu_align.sv
// -----------------------------------------------------------------------------
// mem_lsu_align
// Purely combinational lane logic for the LSU. One instance drives the request
// side (store strobes + replicated store data), another the response side
// (load lane select + sign/zero extension).
// Ports:
//   op        in   ALUOP_W  load/store op code
//   addr_lo   in   2        low address bits (byte lane)
//   st_data   in   32       raw store data (reg2)
//   ld_raw    in   32       raw word returned by memory
//   we        out  4        byte strobes (0 for non-stores)
//   st_wdata  out  32       store data replicated across lanes
//   ld_data   out  32       extracted and extended load data
// -----------------------------------------------------------------------------
module mem_lsu_align
    import mem_lsu_pkg::*;
#(
    parameter int ALUOP_W = 8
) (
    input  logic [ALUOP_W-1:0] op,
    input  logic [1:0]         addr_lo,
    input  logic [31:0]        st_data,
    input  logic [31:0]        ld_raw,
    output logic [3:0]         we,
    output logic [31:0]        st_wdata,
    output logic [31:0]        ld_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Halfwords only ever come from lane 0 or 2, so addr[0] is ignored here.
    assign byte_sel = ld_raw[{addr_lo, 3'b000} +: 8];
    assign half_sel = addr_lo[1] ? ld_raw[31:16] : ld_raw[15:0];

    always_comb begin
        we       = WE_NONE;
        st_wdata = st_data;
        ld_data  = ld_raw;
        case (op)
            EXE_LD_B_OP:  ld_data = {{24{byte_sel[7]}}, byte_sel};
            EXE_LD_BU_OP: ld_data = {24'h0, byte_sel};
            EXE_LD_H_OP:  ld_data = {{16{half_sel[15]}}, half_sel};
            EXE_LD_HU_OP: ld_data = {16'h0, half_sel};
            EXE_ST_B_OP: begin
                we       = WE_BYTE << addr_lo;
                st_wdata = {4{st_data[7:0]}};
            end
            EXE_ST_H_OP: begin
                we       = WE_HALF << {addr_lo[1], 1'b0};
                st_wdata = {2{st_data[15:0]}};
            end
            EXE_ST_W_OP:  we = WE_WORD;
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_lsu.sv
// -----------------------------------------------------------------------------
// mem_lsu
// Memory-access pipeline stage. Takes the execute-stage result, issues data
// memory requests (req/gnt, then rvalid for reads), aligns/extends load data
// and hands a registered, single-cycle-valid result to writeback. The stage
// stalls upstream (in_ready_o low) whenever it is not IDLE.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   flush_i                       kill in-flight instruction
//   in_valid_i / in_ready_o       execute-stage handshake
//   aluop_i, mem_addr_i, reg2_i,
//   wd_i, wreg_i, wdata_i,
//   inst_pc_i                     execute-stage fields
//   dmem_req_o/we_o/addr_o/wdata_o, dmem_gnt_i,
//   dmem_rvalid_i, dmem_rdata_i   data-memory interface
//   out_valid_o, wd_o, wreg_o,
//   wdata_o, inst_pc_o            writeback result
//   ale_o                         misaligned access flag
// Build option: MEM_ALIGN_CHECK_EN enables misaligned-access detection; when
// undefined ale_o is tied low and offending low address bits are ignored.
// -----------------------------------------------------------------------------
module mem_lsu
    import mem_lsu_pkg::*;
#(
    parameter int ALUOP_W   = 8,
    parameter int ADDR_W    = 32,
    parameter int REGADDR_W = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [ALUOP_W-1:0]   aluop_i,
    input  logic [ADDR_W-1:0]    mem_addr_i,
    input  logic [31:0]          reg2_i,
    input  logic [REGADDR_W-1:0] wd_i,
    input  logic                 wreg_i,
    input  logic [31:0]          wdata_i,
    input  logic [31:0]          inst_pc_i,
    output logic                 dmem_req_o,
    output logic [3:0]           dmem_we_o,
    output logic [ADDR_W-1:0]    dmem_addr_o,
    output logic [31:0]          dmem_wdata_o,
    input  logic                 dmem_gnt_i,
    input  logic                 dmem_rvalid_i,
    input  logic [31:0]          dmem_rdata_i,
    output logic                 out_valid_o,
    output logic [REGADDR_W-1:0] wd_o,
    output logic                 wreg_o,
    output logic [31:0]          wdata_o,
    output logic [31:0]          inst_pc_o,
    output logic                 ale_o
);

    lsu_state_e         state;
    logic [ALUOP_W-1:0] op_q;
    logic [1:0]         addr_lo_q;

    logic [3:0]  req_we;
    logic [31:0] req_wdata;
    logic [31:0] req_ld_unused;
    logic [3:0]  rsp_we_unused;
    logic [31:0] rsp_st_unused;
    logic [31:0] rsp_ld;

    // Request side: strobes and lane replication straight from the inputs,
    // so they can be registered into the dmem outputs on acceptance.
    mem_lsu_align #(.ALUOP_W(ALUOP_W)) u_align_req (
        .op       (aluop_i),
        .addr_lo  (mem_addr_i[1:0]),
        .st_data  (reg2_i),
        .ld_raw   (32'h0),
        .we       (req_we),
        .st_wdata (req_wdata),
        .ld_data  (req_ld_unused)
    );

    // Response side: lane select/extension of the returned word.
    mem_lsu_align #(.ALUOP_W(ALUOP_W)) u_align_rsp (
        .op       (op_q),
        .addr_lo  (addr_lo_q),
        .st_data  (32'h0),
        .ld_raw   (dmem_rdata_i),
        .we       (rsp_we_unused),
        .st_wdata (rsp_st_unused),
        .ld_data  (rsp_ld)
    );

    assign in_ready_o = (state == S_IDLE);

`ifdef MEM_ALIGN_CHECK_EN
    logic ale_q;
    assign ale_o = ale_q;
`else
    assign ale_o = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            op_q         <= '0;
            addr_lo_q    <= 2'b00;
            dmem_req_o   <= 1'b0;
            dmem_we_o    <= WE_NONE;
            dmem_addr_o  <= '0;
            dmem_wdata_o <= '0;
            out_valid_o  <= 1'b0;
            wd_o         <= '0;
            wreg_o       <= 1'b0;
            wdata_o      <= '0;
            inst_pc_o    <= '0;
`ifdef MEM_ALIGN_CHECK_EN
            ale_q        <= 1'b0;
`endif
        end else begin
            // Result valid and alignment flag are one-cycle pulses.
            out_valid_o <= 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
            ale_q       <= 1'b0;
`endif
            case (state)
                S_IDLE: begin
                    if (!flush_i && in_valid_i) begin
                        wd_o      <= wd_i;
                        inst_pc_o <= inst_pc_i;
                        op_q      <= aluop_i;
                        addr_lo_q <= mem_addr_i[1:0];
                        if (!(is_load(aluop_i) || is_store(aluop_i))) begin
                            out_valid_o <= 1'b1;
                            wreg_o      <= wreg_i;
                            wdata_o     <= wdata_i;
                        end
`ifdef MEM_ALIGN_CHECK_EN
                        else if (is_misaligned(aluop_i, mem_addr_i[1:0])) begin
                            out_valid_o <= 1'b1;
                            ale_q       <= 1'b1;
                            wreg_o      <= 1'b0;
                            wdata_o     <= '0;
                        end
`endif
                        else begin
                            state        <= S_REQ;
                            dmem_req_o   <= 1'b1;
                            dmem_addr_o  <= {mem_addr_i[ADDR_W-1:2], 2'b00};
                            dmem_we_o    <= req_we;
                            dmem_wdata_o <= req_wdata;
                            // Stores never write the register file.
                            wreg_o       <= is_load(aluop_i) ? wreg_i : 1'b0;
                        end
                    end
                end
                S_REQ: begin
                    if (flush_i) begin
                        dmem_req_o <= 1'b0;
                        // A read granted in the flush cycle will still return
                        // data; swallow it in DRAIN instead of leaking it into
                        // the next access.
                        state <= (dmem_gnt_i && is_load(op_q)) ? S_DRAIN : S_IDLE;
                    end else if (dmem_gnt_i) begin
                        dmem_req_o <= 1'b0;
                        if (is_store(op_q)) begin
                            out_valid_o <= 1'b1;
                            wdata_o     <= '0;
                            state       <= S_IDLE;
                        end else begin
                            state <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (dmem_rvalid_i) begin
                        state <= S_IDLE;
                        if (!flush_i) begin
                            out_valid_o <= 1'b1;
                            wdata_o     <= rsp_ld;
                        end
                    end else if (flush_i) begin
                        state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (dmem_rvalid_i) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_lsu.sv
module tb_mem_lsu;
    import mem_lsu_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  aluop = '0;
    logic [31:0] mem_addr = '0, reg2 = '0, wdata_in = '0, pc_in = '0;
    logic [4:0]  wd_in = '0;
    logic        wreg_in = 1'b0;
    logic        req, gnt = 1'b0, rvalid = 1'b0;
    logic [3:0]  we;
    logic [31:0] daddr, dwdata, rdata = '0;
    logic        out_valid, wreg_out, ale;
    logic [4:0]  wd_out;
    logic [31:0] wdata_out, pc_out;

    int errors = 0;
    int checks = 0;
    string tag = "";

    always #5 clk = ~clk;

    mem_lsu dut (
        .clk(clk), .rst(rst), .flush_i(flush),
        .in_valid_i(in_valid), .in_ready_o(in_ready),
        .aluop_i(aluop), .mem_addr_i(mem_addr), .reg2_i(reg2),
        .wd_i(wd_in), .wreg_i(wreg_in), .wdata_i(wdata_in), .inst_pc_i(pc_in),
        .dmem_req_o(req), .dmem_we_o(we), .dmem_addr_o(daddr), .dmem_wdata_o(dwdata),
        .dmem_gnt_i(gnt), .dmem_rvalid_i(rvalid), .dmem_rdata_i(rdata),
        .out_valid_o(out_valid), .wd_o(wd_out), .wreg_o(wreg_out),
        .wdata_o(wdata_out), .inst_pc_o(pc_out), .ale_o(ale)
    );

    typedef struct {
        logic [7:0]  op;
        logic [31:0] addr, reg2, rdata, alu;
        int          gdly, rdly;
        logic        exp_ale;
        logic [3:0]  exp_we;
        logic [31:0] exp_dwdata, exp_wdata;
        logic        exp_wreg;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s/%s actual=%h expected=%h t=%0t", tag, nm, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic [7:0] op, input logic [31:0] addr, reg2, rdata, alu,
                                input int gdly, rdly, input logic [3:0] ewe,
                                input logic [31:0] edw, ewd, input logic ewreg);
        vec_t v;
        v.op = op; v.addr = addr; v.reg2 = reg2; v.rdata = rdata; v.alu = alu;
        v.gdly = gdly; v.rdly = rdly; v.exp_ale = 1'b0;
        v.exp_we = ewe; v.exp_dwdata = edw; v.exp_wdata = ewd; v.exp_wreg = ewreg;
        return v;
    endfunction

    // Reference model: expected result from the architectural rules, using
    // shifts/masks and arithmetic on the whole word.
    function automatic void model(inout vec_t v);
        int unsigned a, b, h;
        a = v.addr % 4;
        b = (v.rdata >> (8 * a)) & 32'hFF;
        h = (v.rdata >> (16 * (a / 2))) & 32'hFFFF;
        v.exp_ale = 1'b0; v.exp_we = 4'h0; v.exp_dwdata = '0;
        v.exp_wdata = v.alu; v.exp_wreg = 1'b1;
`ifdef MEM_ALIGN_CHECK_EN
        if ((((v.op == EXE_LD_H_OP) || (v.op == EXE_LD_HU_OP) || (v.op == EXE_ST_H_OP)) && (a % 2 != 0)) ||
            (((v.op == EXE_LD_W_OP) || (v.op == EXE_ST_W_OP)) && (a != 0))) begin
            v.exp_ale = 1'b1; v.exp_wreg = 1'b0;
            return;
        end
`endif
        case (v.op)
            EXE_LD_B_OP:  v.exp_wdata = (b >= 128) ? b - 256 : b;
            EXE_LD_BU_OP: v.exp_wdata = b;
            EXE_LD_H_OP:  v.exp_wdata = (h >= 32768) ? h - 65536 : h;
            EXE_LD_HU_OP: v.exp_wdata = h;
            EXE_LD_W_OP:  v.exp_wdata = v.rdata;
            EXE_ST_B_OP: begin
                v.exp_we = 4'(1 << a); v.exp_dwdata = (v.reg2 & 32'hFF) * 32'h01010101; v.exp_wreg = 1'b0;
            end
            EXE_ST_H_OP: begin
                v.exp_we = 4'(3 << (2 * (a / 2))); v.exp_dwdata = (v.reg2 & 32'hFFFF) * 32'h00010001; v.exp_wreg = 1'b0;
            end
            EXE_ST_W_OP: begin
                v.exp_we = 4'hF; v.exp_dwdata = v.reg2; v.exp_wreg = 1'b0;
            end
            default: ;
        endcase
    endfunction

    // Runs one instruction end to end; inputs change and outputs are sampled on negedges.
    task automatic run_vec(input vec_t v);
        logic [4:0]  wd;
        logic [31:0] pc;
        logic        is_ld, is_st;
        wd = 5'($urandom_range(0, 31));
        pc = $urandom;
        is_ld = (v.op == EXE_LD_B_OP) || (v.op == EXE_LD_BU_OP) || (v.op == EXE_LD_H_OP) ||
                (v.op == EXE_LD_HU_OP) || (v.op == EXE_LD_W_OP);
        is_st = (v.op == EXE_ST_B_OP) || (v.op == EXE_ST_H_OP) || (v.op == EXE_ST_W_OP);
        @(negedge clk);
        chk("ready_idle", in_ready, 1);
        in_valid = 1; aluop = v.op; mem_addr = v.addr; reg2 = v.reg2;
        wd_in = wd; wreg_in = 1; wdata_in = v.alu; pc_in = pc;
        @(negedge clk);
        in_valid = 0; mem_addr = $urandom; reg2 = $urandom; wdata_in = $urandom;
        if (v.exp_ale) begin
            chk("ale", ale, 1); chk("ale_valid", out_valid, 1);
            chk("ale_wreg", wreg_out, 0); chk("ale_noreq", req, 0);
        end else if (!is_ld && !is_st) begin
            chk("alu_valid", out_valid, 1); chk("alu_wdata", wdata_out, v.exp_wdata);
            chk("alu_wreg", wreg_out, 1); chk("alu_wd", wd_out, wd);
            chk("alu_pc", pc_out, pc); chk("alu_noreq", req, 0);
        end else begin
            for (int i = 0; i <= v.gdly; i++) begin
                chk("req", req, 1); chk("req_addr", daddr, v.addr & ~32'h3);
                chk("req_we", we, v.exp_we); chk("req_stall", in_ready, 0);
                if (is_st) chk("req_wdata", dwdata, v.exp_dwdata);
                if (i == v.gdly) gnt = 1;
                @(negedge clk);
            end
            gnt = 0;
            chk("req_drop", req, 0);
            if (is_st) begin
                chk("st_valid", out_valid, 1); chk("st_wreg", wreg_out, 0); chk("st_pc", pc_out, pc);
            end else begin
                for (int i = 0; i <= v.rdly; i++) begin
                    chk("wait_novalid", out_valid, 0); chk("wait_stall", in_ready, 0);
                    if (i == v.rdly) begin rvalid = 1; rdata = v.rdata; end
                    else rdata = $urandom;
                    @(negedge clk);
                end
                rvalid = 0; rdata = $urandom;
                chk("ld_valid", out_valid, 1); chk("ld_wdata", wdata_out, v.exp_wdata);
                chk("ld_wreg", wreg_out, 1); chk("ld_wd", wd_out, wd); chk("ld_pc", pc_out, pc);
            end
        end
        @(negedge clk);
        chk("pulse", out_valid, 0); chk("ale_pulse", ale, 0);
    endtask

    // Accept a load and get it granted; returns with the DUT in WAIT.
    task automatic start_load(input logic [31:0] addr);
        @(negedge clk);
        in_valid = 1; aluop = EXE_LD_W_OP; mem_addr = addr; wreg_in = 1;
        @(negedge clk);
        in_valid = 0; gnt = 1;
        @(negedge clk);
        gnt = 0;
    endtask

    vec_t vecs[10];
    vec_t v;
    logic [7:0] ops[9];

    initial begin
        vecs[0] = mk(EXE_ADD_OP,   32'h0, 32'h0,        32'h0,        32'h12345678, 0, 0, 4'h0, 32'h0,        32'h12345678, 1);
        vecs[1] = mk(EXE_LD_B_OP,  32'h1003, 32'h0,     32'h80FF0000, 32'h0, 2, 0, 4'h0, 32'h0,        32'hFFFFFF80, 1);
        vecs[2] = mk(EXE_LD_HU_OP, 32'h2002, 32'h0,     32'hBEEF1234, 32'h0, 0, 0, 4'h0, 32'h0,        32'h0000BEEF, 1);
        vecs[3] = mk(EXE_ST_H_OP,  32'h3002, 32'hAAAA5555, 32'h0,     32'h0, 0, 0, 4'hC, 32'h55555555, 32'h0,        0);
        vecs[4] = mk(EXE_LD_BU_OP, 32'h1001, 32'h0,     32'h12345678, 32'h0, 0, 1, 4'h0, 32'h0,        32'h00000056, 1);
        vecs[5] = mk(EXE_LD_H_OP,  32'h2000, 32'h0,     32'h12348001, 32'h0, 1, 0, 4'h0, 32'h0,        32'hFFFF8001, 1);
        vecs[6] = mk(EXE_LD_W_OP,  32'h6004, 32'h0,     32'hDEADBEEF, 32'h0, 1, 3, 4'h0, 32'h0,        32'hDEADBEEF, 1);
        vecs[7] = mk(EXE_ST_B_OP,  32'h7001, 32'h000000A5, 32'h0,     32'h0, 0, 0, 4'h2, 32'hA5A5A5A5, 32'h0,        0);
        vecs[8] = mk(EXE_ST_W_OP,  32'h7008, 32'hCAFEF00D, 32'h0,     32'h0, 2, 0, 4'hF, 32'hCAFEF00D, 32'h0,        0);
        vecs[9] = mk(EXE_LD_B_OP,  32'h1000, 32'h0,     32'h0000007F, 32'h0, 0, 0, 4'h0, 32'h0,        32'h0000007F, 1);
        ops = '{EXE_ADD_OP, EXE_LD_B_OP, EXE_LD_BU_OP, EXE_LD_H_OP, EXE_LD_HU_OP,
                EXE_LD_W_OP, EXE_ST_B_OP, EXE_ST_H_OP, EXE_ST_W_OP};

        // Reset state
        tag = "reset";
        repeat (2) @(negedge clk);
        rst = 0;
        chk("ready", in_ready, 1); chk("valid", out_valid, 0); chk("req", req, 0);
        chk("we", we, 0); chk("wdata", wdata_out, 0); chk("wreg", wreg_out, 0); chk("ale", ale, 0);

        // Directed table
        for (int i = 0; i < 10; i++) begin
            tag = $sformatf("vec%0d", i);
            run_vec(vecs[i]);
        end

        // Misaligned word load
        tag = "misalign";
        v = mk(EXE_LD_W_OP, 32'h4001, 32'h0, 32'h11223344, 32'h0, 0, 0, 4'h0, 32'h0, 32'h11223344, 1);
`ifdef MEM_ALIGN_CHECK_EN
        v.exp_ale = 1'b1; v.exp_wreg = 1'b0;
`endif
        run_vec(v);
        tag = "misalign_h";
        v = mk(EXE_LD_H_OP, 32'h4003, 32'h0, 32'h9ABC0000, 32'h0, 0, 0, 4'h0, 32'h0, 32'hFFFF9ABC, 1);
`ifdef MEM_ALIGN_CHECK_EN
        v.exp_ale = 1'b1; v.exp_wreg = 1'b0;
`endif
        run_vec(v);

        // Flush in WAIT, late rvalid consumed by DRAIN before the next instruction
        tag = "flush_wait";
        start_load(32'h5000);
        flush = 1;
        @(negedge clk);
        flush = 0;
        in_valid = 1; aluop = EXE_ADD_OP; wdata_in = 32'h0BADF00D; wreg_in = 1;
        chk("drain_novalid", out_valid, 0); chk("drain_stall", in_ready, 0);
        @(negedge clk);
        chk("drain_stall2", in_ready, 0); chk("drain_novalid2", out_valid, 0);
        rvalid = 1; rdata = 32'h55AA55AA;
        @(negedge clk);
        rvalid = 0;
        chk("drain_drop", out_valid, 0); chk("drain_ready", in_ready, 1);
        @(negedge clk);
        in_valid = 0;
        chk("after_valid", out_valid, 1); chk("after_wdata", wdata_out, 32'h0BADF00D);

        // Flush in REQ drops the request
        tag = "flush_req";
        @(negedge clk);
        in_valid = 1; aluop = EXE_ST_W_OP; mem_addr = 32'h8000; reg2 = 32'h1;
        @(negedge clk);
        in_valid = 0; flush = 1;
        chk("req_up", req, 1);
        @(negedge clk);
        flush = 0;
        chk("req_dropped", req, 0); chk("ready", in_ready, 1); chk("novalid", out_valid, 0);

        // Flush coinciding with rvalid drops the result
        tag = "flush_rvalid";
        start_load(32'h9000);
        flush = 1; rvalid = 1; rdata = 32'h12345678;
        @(negedge clk);
        flush = 0; rvalid = 0;
        chk("novalid", out_valid, 0); chk("ready", in_ready, 1);

        // Flush beats in_valid in IDLE
        tag = "flush_idle";
        in_valid = 1; flush = 1; aluop = EXE_ADD_OP;
        @(negedge clk);
        in_valid = 0; flush = 0;
        chk("novalid", out_valid, 0); chk("ready", in_ready, 1);

        // Reset mid-access
        tag = "rst_mid";
        @(negedge clk);
        in_valid = 1; aluop = EXE_LD_W_OP; mem_addr = 32'hA000;
        @(negedge clk);
        in_valid = 0; rst = 1;
        @(negedge clk);
        rst = 0;
        chk("req", req, 0); chk("ready", in_ready, 1); chk("valid", out_valid, 0);

        // Randomised against the reference model
        for (int i = 0; i < 60; i++) begin
            tag = $sformatf("rnd%0d", i);
            v.op = ops[$urandom_range(0, 8)];
            v.addr = $urandom; v.reg2 = $urandom; v.rdata = $urandom; v.alu = $urandom;
            v.gdly = $urandom_range(0, 3); v.rdly = $urandom_range(0, 3);
            model(v);
            run_vec(v);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_lsu.md
Name: mem_lsu

Overview:
- Memory-access stage directly downstream of the execute stage.
- Consumes the execute stage's ALU op, effective address, store data (reg2), destination register, write enable, ALU result and PC.
- Issues data-memory requests over a req/gnt + rvalid handshake, then aligns and sign/zero-extends load data.
- Presents a registered result to writeback and stalls the pipeline while an access is outstanding.

Parameters:
- ALUOP_W, 8, width of the ALU op field; same encoding as the execute stage's op codes.
- ADDR_W, 32, data address width.
- REGADDR_W, 5, register index width.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- flush_i  in  1  kill the in-flight instruction (exception/branch redirect)
- in_valid_i  in  1  execute stage offers an instruction
- in_ready_o  out  1  stage can accept; low means stall upstream
- aluop_i  in  ALUOP_W  operation code
- mem_addr_i  in  ADDR_W  effective address
- reg2_i  in  32  store data
- wd_i  in  REGADDR_W  destination register
- wreg_i  in  1  register write enable
- wdata_i  in  32  ALU result
- inst_pc_i  in  32  instruction PC
- dmem_req_o  out  1  memory request
- dmem_we_o  out  4  byte write strobes; 0 = read
- dmem_addr_o  out  ADDR_W  word-aligned address (low 2 bits zero)
- dmem_wdata_o  out  32  store data, lane-replicated
- dmem_gnt_i  in  1  request accepted
- dmem_rvalid_i  in  1  read data valid
- dmem_rdata_i  in  32  read data
- out_valid_o  out  1  result valid to writeback
- wd_o  out  REGADDR_W  destination register to writeback
- wreg_o  out  1  register write enable to writeback
- wdata_o  out  32  result data to writeback
- inst_pc_o  out  32  instruction PC to writeback
- ale_o  out  1  misaligned-address flag (optional feature only)

Behaviour:
- Reset: rst is synchronous, active-high. On reset the state is IDLE and every output is 0, except in_ready_o = 1. Reset mid-access abandons the access; no rvalid is expected afterwards.
- States: IDLE, REQ, WAIT, DRAIN.
- IDLE, with in_valid_i & in_ready_o:
  - Non-memory op: capture the passthrough fields. Next cycle out_valid_o = 1, wdata_o = wdata_i. Latency 1.
  - Load or store: latch op, addr and data; go to REQ.
- in_ready_o = 1 only in IDLE.
- REQ:
  - dmem_req_o held high with addr/we/wdata stable until dmem_gnt_i.
  - Store granted: next cycle out_valid_o = 1 with wreg_o = 0; return to IDLE.
  - Load granted: go to WAIT.
- WAIT: on dmem_rvalid_i, select the lane by addr[1:0] and extend the data.
  - LD.B / LD.BU: byte, sign- / zero-extended.
  - LD.H / LD.HU: halfword at addr[1], sign- / zero-extended.
  - LD.W: whole word.
  - Next cycle out_valid_o = 1 and wdata_o = extended data; return to IDLE. Minimum load latency 3 cycles when gnt and rvalid each arrive in their first cycle.
- Store lanes:
  - ST.B: we = 1 << addr[1:0]; wdata = {4{reg2[7:0]}}.
  - ST.H: we = 4'b0011 << {addr[1],1'b0}; wdata = {2{reg2[15:0]}}.
  - ST.W: we = 4'hF.
- out_valid_o is a single-cycle pulse; writeback never stalls.
- flush_i:
  - Has priority over in_valid_i; clears out_valid_o the next cycle.
  - In REQ: drop dmem_req_o; go to IDLE.
  - In WAIT: go to DRAIN, which discards the pending rvalid and then returns to IDLE (in_ready_o stays 0 in DRAIN).
  - Flush in IDLE, or in the same cycle as rvalid in WAIT: the result is dropped and the state goes to IDLE.
- Simultaneous gnt and rvalid in the same cycle is illegal: the slave returns rvalid at least 1 cycle after gnt.

Optional Feature:
- MEM_ALIGN_CHECK_EN defined:
  - Halfword access with addr[0] set, or word access with addr[1:0] != 0, issues no request.
  - ale_o = 1 and out_valid_o = 1 for one cycle with wreg_o = 0.
- Undefined: ale_o tied 0; offending low address bits are ignored, so the access uses the aligned word and lane 0/2.

Decomposition:
- Shared defines/package:
  - Load/store op codes (EXE_LD_B/H/W/BU/HU_OP, EXE_ST_B/H/W_OP).
  - State encoding (2 bits).
  - Strobe constants.
- Sub-module lsu_align: combinational load extraction/extension and store strobe/replication. Used twice, request side and response side.

Test Plan:
- ADD result 0x12345678, wd = 5 -> out_valid_o high 1 cycle later; wdata_o = 0x12345678, wreg_o = 1, no dmem_req_o.
- LD.B addr 0x1003, rdata 0x80FF_0000, gnt after 2 wait cycles -> dmem_addr_o = 0x1000; wdata_o = 0xFFFFFF80; in_ready_o low until result.
- LD.HU addr 0x2002, rdata 0xBEEF_1234 -> wdata_o = 0x0000BEEF.
- ST.H addr 0x3002, reg2 = 0xAAAA5555 -> dmem_we_o = 4'b1100, dmem_wdata_o = 0x55555555; out_valid_o with wreg_o = 0 the cycle after gnt.
- LD.W flushed in WAIT, then a late rvalid -> no out_valid_o; next instruction accepted only after DRAIN consumes rvalid.
- MEM_ALIGN_CHECK_EN, LD.W addr 0x4001 -> no dmem_req_o; ale_o = 1 for 1 cycle.
